// File: rtl/song_pkg.sv
// Shared types for the song sequencer: note codes, ROM entry layout, FSM states
// and small helpers for beat counts, note selection and manual key decoding.
package song_pkg;

    localparam int SONG_LEN = 16;
    localparam int DUR_W    = 3;
    localparam int IDX_W    = $clog2(SONG_LEN);
    localparam int BEAT_W   = DUR_W + 1;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_C4   = 4'd1;
    localparam note_t NOTE_D4   = 4'd2;
    localparam note_t NOTE_E4   = 4'd3;
    localparam note_t NOTE_F4   = 4'd4;
    localparam note_t NOTE_G4   = 4'd5;
    localparam note_t NOTE_A4   = 4'd6;
    localparam note_t NOTE_B4   = 4'd7;
    localparam note_t NOTE_C5   = 4'd8;

    typedef struct packed {
        note_t            code;
        logic [DUR_W-1:0] dur;
    } song_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A stored duration of zero stands for the full 2^DUR_W beats.
    function automatic logic [BEAT_W-1:0] dur_beats(input logic [DUR_W-1:0] dur);
        if (dur == {DUR_W{1'b0}}) begin
            dur_beats = {1'b1, {DUR_W{1'b0}}};
        end else begin
            dur_beats = {1'b0, dur};
        end
    endfunction

    function automatic logic note_wave(input note_t code, input logic [7:0] clks);
        case (code)
            4'd1:    note_wave = clks[0];
            4'd2:    note_wave = clks[1];
            4'd3:    note_wave = clks[2];
            4'd4:    note_wave = clks[3];
            4'd5:    note_wave = clks[4];
            4'd6:    note_wave = clks[5];
            4'd7:    note_wave = clks[6];
            4'd8:    note_wave = clks[7];
            default: note_wave = 1'b0;
        endcase
    endfunction

    function automatic note_t lowest_key(input logic [7:0] keys);
        lowest_key = NOTE_REST;
        for (int i = 7; i >= 0; i--) begin
            if (keys[i]) begin
                lowest_key = 4'(i + 1);
            end else begin
                lowest_key = lowest_key;
            end
        end
    endfunction

endpackage

// File: rtl/song_rom.sv
// Fixed song table: combinational lookup from ROM index to {note code, duration}.
module song_rom
    import song_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output song_entry_t      entry_o
);

    // Song contents; entry 9 holds an out-of-range code that plays as a rest.
    always_comb begin
        case (idx_i)
            4'd0:    entry_o = '{code: NOTE_C4,   dur: 3'd2};
            4'd1:    entry_o = '{code: NOTE_D4,   dur: 3'd1};
            4'd2:    entry_o = '{code: NOTE_E4,   dur: 3'd1};
            4'd3:    entry_o = '{code: NOTE_REST, dur: 3'd2};
            4'd4:    entry_o = '{code: NOTE_F4,   dur: 3'd3};
            4'd5:    entry_o = '{code: NOTE_G4,   dur: 3'd0};
            4'd6:    entry_o = '{code: NOTE_A4,   dur: 3'd1};
            4'd7:    entry_o = '{code: NOTE_B4,   dur: 3'd1};
            4'd8:    entry_o = '{code: NOTE_C5,   dur: 3'd1};
            4'd9:    entry_o = '{code: 4'd9,      dur: 3'd1};
            4'd10:   entry_o = '{code: NOTE_G4,   dur: 3'd1};
            4'd11:   entry_o = '{code: NOTE_F4,   dur: 3'd1};
            4'd12:   entry_o = '{code: NOTE_E4,   dur: 3'd1};
            4'd13:   entry_o = '{code: NOTE_D4,   dur: 3'd1};
            4'd14:   entry_o = '{code: NOTE_C4,   dur: 3'd1};
            4'd15:   entry_o = '{code: NOTE_C5,   dur: 3'd2};
            default: entry_o = '{code: NOTE_REST, dur: 3'd1};
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps through the ROM song on QUARTER_BEAT rising edges and drives SPEAKER.
// Optional manual piano keys are enabled by defining SONG_SEQ_MANUAL_EN.
module song_sequencer
    import song_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       NOTE_CLK,
    input  logic             QUARTER_BEAT,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic             LOOP,
`ifdef SONG_SEQ_MANUAL_EN
    input  logic [7:0]       KEYS,
`endif
    output logic             SPEAKER,
    output logic [3:0]       NOTE_CODE,
    output logic [IDX_W-1:0] SONG_IDX,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic                qb_q;
    logic                speaker_q, speaker_d;
    note_t               code_q, code_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick_s;
    logic                load_s;
    logic                dec_s;
    song_entry_t         entry_s;

    assign tick_s = QUARTER_BEAT & ~qb_q;

    // The ROM is addressed by the next index so reloads and NOTE_CODE track SONG_IDX.
    song_rom u_rom (
        .idx_i   (idx_d),
        .entry_o (entry_s)
    );

    // Next state and index; STOP overrides everything, PAUSE beats a same-cycle tick.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        if (STOP) begin
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d = {IDX_W{1'b0}};
                    if (START) begin
                        state_d = ST_PLAY;
                        load_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSE;
                    end else if (tick_s) begin
                        if (beats_q > BEAT_W'(1)) begin
                            dec_s = 1'b1;
                        end else if (idx_q != LAST_IDX) begin
                            idx_d  = idx_q + IDX_W'(1);
                            load_s = 1'b1;
                        end else if (LOOP) begin
                            idx_d  = {IDX_W{1'b0}};
                            load_s = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            idx_d   = {IDX_W{1'b0}};
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Beat counter and registered output values derived from the next state.
    always_comb begin
        beats_d   = beats_q;
        code_d    = NOTE_REST;
        speaker_d = 1'b0;
        if (STOP) begin
            beats_d = {BEAT_W{1'b0}};
        end else if (load_s) begin
            beats_d = dur_beats(entry_s.dur);
        end else if (dec_s) begin
            beats_d = beats_q - BEAT_W'(1);
        end else begin
            beats_d = beats_q;
        end
        if (state_d == ST_PLAY) begin
            code_d    = entry_s.code;
            speaker_d = note_wave(entry_s.code, NOTE_CLK);
        end else begin
            code_d    = NOTE_REST;
            speaker_d = 1'b0;
        end
`ifdef SONG_SEQ_MANUAL_EN
        if (KEYS != 8'h00) begin
            code_d = lowest_key(KEYS);
            if (state_d == ST_IDLE || state_d == ST_PLAY) begin
                speaker_d = |(NOTE_CLK & KEYS);
            end else begin
                speaker_d = 1'b0;
            end
        end else begin
            code_d = code_d;
        end
`endif
        busy_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers, cleared asynchronously by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            beats_q   <= {BEAT_W{1'b0}};
            qb_q      <= 1'b0;
            speaker_q <= 1'b0;
            code_q    <= NOTE_REST;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            beats_q   <= beats_d;
            qb_q      <= QUARTER_BEAT;
            speaker_q <= speaker_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SPEAKER   = speaker_q;
    assign NOTE_CODE = code_q;
    assign SONG_IDX  = idx_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed, table-driven bench for song_sequencer with hand-computed expectations.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] nclk;
    logic       qb, start, stop, pause, loop;
    logic       spk, busy, done;
    logic [3:0] code, idx;
`ifdef SONG_SEQ_MANUAL_EN
    logic [7:0] keys = 8'h00;
`endif

    int checks   = 0;
    int failures = 0;

    song_sequencer dut (
        .CLK          (clk),
        .RESET        (rst),
        .NOTE_CLK     (nclk),
        .QUARTER_BEAT (qb),
        .START        (start),
        .STOP         (stop),
        .PAUSE        (pause),
        .LOOP         (loop),
`ifdef SONG_SEQ_MANUAL_EN
        .KEYS         (keys),
`endif
        .SPEAKER      (spk),
        .NOTE_CODE    (code),
        .SONG_IDX     (idx),
        .BUSY         (busy),
        .DONE         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, pause, loop, qb;
        logic [7:0] nclk;
        logic       spk;
        logic [3:0] code, idx;
        logic       busy, done;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic e_spk, input logic [3:0] e_code,
                             input logic [3:0] e_idx, input logic e_busy, input logic e_done);
        check({name, ".spk"},  {7'd0, spk},  {7'd0, e_spk});
        check({name, ".code"}, {4'd0, code}, {4'd0, e_code});
        check({name, ".idx"},  {4'd0, idx},  {4'd0, e_idx});
        check({name, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
        check({name, ".done"}, {7'd0, done}, {7'd0, e_done});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n);
        for (int b = 0; b < n; b++) begin
            qb = 1'b1;
            cyc();
            qb = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             start stop  pause loop  qb    nclk   spk   code  idx   busy  done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};

        rst = 1'b1; nclk = 8'hFF; qb = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        cyc();
        cyc();
        check_all("reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            loop  = vecs[i].loop;  qb   = vecs[i].qb;   nclk  = vecs[i].nclk;
            cyc();
            check_all($sformatf("vec%0d", i), vecs[i].spk, vecs[i].code, vecs[i].idx,
                      vecs[i].busy, vecs[i].done);
        end
        start = 1'b0; stop = 1'b0; qb = 1'b0; nclk = 8'hFF;

        // From index 0 (2 beats) walk to the rest entry at index 3.
        beats(4);
        check_all("rest_start", 1'b0, 4'd0, 4'd3, 1'b1, 1'b0);
        beats(1);
        check_all("rest_hold", 1'b0, 4'd0, 4'd3, 1'b1, 1'b0);
        beats(2);
        check_all("idx4_beat1", 1'b1, 4'd4, 4'd4, 1'b1, 1'b0);

        // Pause arrives together with a tick at index 4, beats_left=2.
        pause = 1'b1; qb = 1'b1;
        cyc();
        check_all("pause_enter", 1'b0, 4'd0, 4'd4, 1'b1, 1'b0);
        qb = 1'b0;
        cyc();
        beats(2);
        check_all("pause_hold", 1'b0, 4'd0, 4'd4, 1'b1, 1'b0);
        pause = 1'b0;
        cyc();
        check_all("pause_exit", 1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        beats(1);
        check_all("after_pause_t1", 1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        beats(1);
        check_all("after_pause_t2", 1'b1, 4'd5, 4'd5, 1'b1, 1'b0);

        // Index 5 has a zero duration field: eight beats.
        beats(7);
        check_all("dur0_b7", 1'b1, 4'd5, 4'd5, 1'b1, 1'b0);
        beats(1);
        check_all("dur0_b8", 1'b1, 4'd6, 4'd6, 1'b1, 1'b0);
        beats(3);
        check_all("code9_rest", 1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
        beats(6);
        check_all("last_idx", 1'b1, 4'd8, 4'd15, 1'b1, 1'b0);

        loop = 1'b1;
        beats(1);
        check_all("loop_pre", 1'b1, 4'd8, 4'd15, 1'b1, 1'b0);
        beats(1);
        check_all("loop_wrap", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);

        // Full song without looping: 28 beats total.
        loop = 1'b0;
        beats(27);
        check_all("end_pre", 1'b1, 4'd8, 4'd15, 1'b1, 1'b0);
        qb = 1'b1;
        cyc();
        check_all("done_pulse", 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        qb = 1'b0;
        cyc();
        check_all("done_clear", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of index 5.
        start = 1'b1;
        cyc();
        start = 1'b0;
        beats(9);
        check_all("pre_reset", 1'b1, 4'd5, 4'd5, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("async_reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        check_all("post_reset_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_all("restart", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
        beats(1);
        check_all("restart_t1", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
        beats(1);
        check_all("restart_t2", 1'b1, 4'd2, 4'd1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Consumes the eight note square waves and QUARTER_BEAT produced by the note clock manager.
- Steps through a fixed song stored in ROM, one entry per note, each entry lasting a given number of beats.
- Drives one SPEAKER output with the selected note's square wave.
- Provides start/stop/pause/loop control and status for the board-level top.

Parameters:
- SONG_LEN, 16: number of ROM entries; index width = clog2(SONG_LEN).
- DUR_W, 3: duration field width in beats. A stored value of 0 means 2^DUR_W beats.

Ports:
- CLK  in  1  system clock, same domain as the note clock manager.
- RESET  in  1  asynchronous, active-high.
- NOTE_CLK  in  8  note square waves; bit0=C4, D, E, F, G, A, B, bit7=C5.
- QUARTER_BEAT  in  1  beat toggle from clock manager, synchronous to CLK.
- START  in  1  one-cycle pulse; begin playback from entry 0.
- STOP  in  1  one-cycle pulse; abort to idle.
- PAUSE  in  1  level; freezes playback while high.
- LOOP  in  1  level; sampled at end of song.
- SPEAKER  out  1  audio square wave, registered.
- NOTE_CODE  out  4  code of the note currently playing; 0 when not playing.
- SONG_IDX  out  clog2(SONG_LEN)  current ROM index.
- BUSY  out  1  high in PLAY or PAUSE.
- DONE  out  1  one-cycle pulse when the song ends without looping.

Behaviour:
- Reset: all state cleared asynchronously. Outputs reset to SPEAKER=0, NOTE_CODE=0, SONG_IDX=0, BUSY=0, DONE=0; FSM in IDLE.
- Beat tick:
  - qb_d holds QUARTER_BEAT delayed by one CLK.
  - tick = QUARTER_BEAT & ~qb_d, a single-CLK pulse on each rising edge.
  - qb_d resets to 0. No synchronizer, because the source is in the same clock domain.
- FSM states: IDLE, PLAY, PAUSE, DONE.
  - IDLE: on START go to PLAY; SONG_IDX=0; beats_left = dur(ROM[0]).
  - PLAY, with PAUSE=1: go to PAUSE.
  - PLAY, tick with beats_left>1: beats_left decrements.
  - PLAY, tick with beats_left==1 and SONG_IDX<SONG_LEN-1: SONG_IDX increments; beats_left = dur(ROM[SONG_IDX+1]).
  - PLAY, tick with beats_left==1 at the last index, LOOP=1: SONG_IDX=0; reload dur(ROM[0]).
  - PLAY, tick with beats_left==1 at the last index, LOOP=0: go to DONE.
  - PAUSE: ticks are ignored; SONG_IDX and beats_left are held. On PAUSE=0 return to PLAY.
  - DONE: lasts one cycle; DONE=1; next state IDLE with SONG_IDX=0.
- Priority:
  - STOP in any state goes to IDLE next cycle and overrides START, PAUSE and tick in the same cycle.
  - START in PLAY or PAUSE is ignored.
  - PAUSE high in the same cycle as a tick in PLAY: the pause wins and the tick is discarded.
- Note codes: 0=rest, 1..8 = C4..C5; 9..15 are treated as rest.
- Speaker:
  - SPEAKER is registered: SPEAKER <= NOTE_CLK[code-1] in PLAY with code 1..8, otherwise 0.
  - One CLK of latency from a NOTE_CLK edge to SPEAKER.
- NOTE_CODE equals the ROM code in PLAY and is 0 in IDLE, PAUSE and DONE. It is registered and updates in the same cycle as SONG_IDX.
- BUSY is registered and equals (state==PLAY || state==PAUSE).

Optional Feature:
- Macro: SONG_SEQ_MANUAL_EN.
- When defined:
  - An extra input KEYS (8 bits, one-hot piano keys) is present.
  - In IDLE, SPEAKER <= OR of NOTE_CLK & KEYS, so multiple keys mix by OR.
  - In PLAY, any nonzero KEYS overrides the ROM note on SPEAKER. Sequencing continues unaffected.
  - NOTE_CODE reports the lowest pressed key while KEYS!=0.
- When not defined: no KEYS port; SPEAKER is 0 in IDLE.

Decomposition:
- Package song_pkg:
  - note code constants NOTE_REST=0, NOTE_C4=1 … NOTE_C5=8;
  - the 4-bit note_t typedef;
  - the song entry struct {note_t code; logic [DUR_W-1:0] dur};
  - the state enum.
- Sub-module song_rom: combinational lookup from index to entry, holding the SONG_LEN-entry song table.

Test Plan:
- Reset asserted mid-PLAY at SONG_IDX=5 -> all outputs 0 at once (asynchronous); FSM in IDLE; after release, START restarts at index 0.
- ROM[0]={C4,dur 2}, START, then 2 ticks -> SPEAKER follows NOTE_CLK[0] one CLK late; SONG_IDX goes 0->1 on the second tick.
- Song ends with LOOP=0 -> DONE pulses exactly 1 cycle; BUSY falls the same cycle; SONG_IDX=0.
- Song ends with LOOP=1 -> SONG_IDX wraps 15->0; no DONE pulse; BUSY stays 1.
- PAUSE high across 3 ticks at index 4 with beats_left=2 -> SPEAKER=0, index and beats_left unchanged; after release, 2 more ticks are needed to advance.
- START and STOP in the same cycle from IDLE -> stays IDLE. Rest entry (code 0) -> SPEAKER=0 for its duration. Duration field 0 -> entry lasts 8 beats.
